// File: rtl/serial_adder_n_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_n_pkg;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Width of the digit index counter: clog2(ndig), never below one bit
    function automatic int unsigned idx_width(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_adder_n_adder_digit.sv
// DIGIT-bit ripple-carry slice; one instance is time-shared across all digits.
module adder_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic carry;

    // Ripple the carry through the slice bit by bit
    always_comb begin
        s     = '0;
        carry = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial two's-complement adder/subtractor with start/busy/done handshake.
module serial_adder_n
    import serial_adder_n_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IDXW = idx_width(NDIG);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    // Reject illegal parameter combinations at elaboration
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder_n: illegal WIDTH/DIGIT combination");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_co;
    logic             accept;

    // Select the current digit of both operands
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (idx_q == IDXW'(i)) begin
                dig_a = a_q[i*DIGIT +: DIGIT];
                dig_b = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    adder_digit #(
        .DIGIT (DIGIT)
    ) u_adder_digit (
        .a  (dig_a),
        .b  (dig_b),
        .ci (c_q),
        .s  (dig_s),
        .co (dig_co)
    );

    // Next-state, datapath and flag update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        accept  = start && (state_q == S_IDLE || state_q == S_DONE);

        unique case (state_q)
            S_RUN: begin
                for (int i = 0; i < int'(NDIG); i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[i*DIGIT +: DIGIT] = dig_s;
                    end
                end
                c_d   = dig_co;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    cout_d  = dig_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = ~|sum_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
        endcase

        // Accept in IDLE or DONE; DONE-accept gives back-to-back operation
        if (accept) begin
            state_d = S_RUN;
            a_d     = A;
            b_d     = sub ? ~B : B;
            c_d     = sub ? 1'b1 : cin;
            idx_d   = '0;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
